// File: rtl/rfin_packet_rx_if.sv
// Signal bundle between the RF pulse receiver and its host-side logic.
// The receiver takes the slave modport; the host or bench drives the master side.
interface rfin_packet_rx_if #(
   parameter int unsigned PACKET_SIZE = 24,
   parameter int unsigned CNT_W       = 16
);
   logic                   rfin;
   logic                   rx_en;
   logic [CNT_W-1:0]       count_val;
   logic [PACKET_SIZE-1:0] pkt_data;
   logic                   pkt_rec;
   logic                   busy;
   logic                   sync_err;

   modport master (
      output rfin, rx_en, count_val,
      input  pkt_data, pkt_rec, busy, sync_err
   );

   modport slave (
      input  rfin, rx_en, count_val,
      output pkt_data, pkt_rec, busy, sync_err
   );
endinterface

// File: rtl/rfin_packet_rx.sv
// Bit-synchronous RF pulse receiver: all-ones preamble lock, then one data bit per period.
// Define RFIN_GLITCH_FILTER_EN to require two consecutive high samples per pulse.
module rfin_packet_rx #(
   parameter int unsigned PACKET_SIZE  = 24,
   parameter int unsigned PREAMBLE_LEN = 8,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   rfin_packet_rx_if.slave  bus
);
   localparam int unsigned ONES_W = $clog2(PREAMBLE_LEN + 1);
   localparam int unsigned BITS_W = $clog2(PACKET_SIZE + 1);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DONE} state_t;

   state_t                 state, state_n;
   logic                   rfin_s1, rfin_s2, rfin_s3, pulse;
   logic [CNT_W-1:0]       phase, phase_n, period, period_n, half;
   logic                   hit, hit_n, decide;
   logic [ONES_W-1:0]      ones, ones_n;
   logic [BITS_W-1:0]      bits, bits_n;
   logic [PACKET_SIZE-1:0] shreg, shreg_n, pkt_data, pkt_data_n;
   logic                   sync_err, sync_err_n;

`ifdef RFIN_GLITCH_FILTER_EN
   logic                   qual_d;
`endif

   // Two-flop synchronizer followed by a registered rising-edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         rfin_s1 <= 1'b0;
         rfin_s2 <= 1'b0;
         rfin_s3 <= 1'b0;
         pulse   <= 1'b0;
`ifdef RFIN_GLITCH_FILTER_EN
         qual_d  <= 1'b0;
`endif
      end else begin
         rfin_s1 <= bus.rfin;
         rfin_s2 <= rfin_s1;
         rfin_s3 <= rfin_s2;
`ifdef RFIN_GLITCH_FILTER_EN
         qual_d  <= rfin_s2 & rfin_s3;
         pulse   <= rfin_s2 & rfin_s3 & ~qual_d;
`else
         pulse   <= rfin_s2 & ~rfin_s3;
`endif
      end
   end

   assign half = period >> 1;

   always_comb begin
      state_n    = state;
      phase_n    = phase;
      hit_n      = hit;
      ones_n     = ones;
      bits_n     = bits;
      period_n   = period;
      shreg_n    = shreg;
      pkt_data_n = pkt_data;
      sync_err_n = 1'b0;
      decide     = 1'b0;

      // A pulse re-anchors the bit grid and pre-empts a decision in the same cycle.
      if (state == PREAMBLE || state == DATA) begin
         if (pulse) begin
            phase_n = '0;
            hit_n   = 1'b1;
         end else begin
            if (phase == period - CNT_W'(1)) phase_n = '0;
            else                             phase_n = phase + CNT_W'(1);
            if (phase == half) begin
               decide = 1'b1;
               hit_n  = 1'b0;
            end
         end
      end

      case (state)
         IDLE: begin
            phase_n = '0;
            hit_n   = 1'b0;
            if (pulse && bus.rx_en) begin
               state_n  = PREAMBLE;
               hit_n    = 1'b1;
               ones_n   = '0;
               period_n = (bus.count_val < CNT_W'(4)) ? CNT_W'(4) : bus.count_val;
            end
         end
         PREAMBLE: begin
            if (decide) begin
               if (hit) begin
                  ones_n = ones + ONES_W'(1);
                  if (ones_n == ONES_W'(PREAMBLE_LEN)) begin
                     state_n = DATA;
                     bits_n  = '0;
                  end
               end else begin
                  state_n    = IDLE;
                  sync_err_n = 1'b1;
               end
            end
         end
         DATA: begin
            if (decide) begin
               shreg_n = {shreg[PACKET_SIZE-2:0], hit};
               bits_n  = bits + BITS_W'(1);
               // Publish on the final decision so pkt_data is valid alongside pkt_rec.
               if (bits_n == BITS_W'(PACKET_SIZE)) begin
                  state_n    = DONE;
                  pkt_data_n = shreg_n;
               end
            end
         end
         default: begin
            state_n = IDLE;
            phase_n = '0;
            hit_n   = 1'b0;
         end
      endcase

      if (!bus.rx_en) begin
         state_n    = IDLE;
         phase_n    = '0;
         hit_n      = 1'b0;
         pkt_data_n = pkt_data;
         sync_err_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= '0;
         period   <= '0;
         hit      <= 1'b0;
         ones     <= '0;
         bits     <= '0;
         shreg    <= '0;
         pkt_data <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         period   <= period_n;
         hit      <= hit_n;
         ones     <= ones_n;
         bits     <= bits_n;
         shreg    <= shreg_n;
         pkt_data <= pkt_data_n;
         sync_err <= sync_err_n;
      end
   end

   assign bus.pkt_data = pkt_data;
   assign bus.pkt_rec  = (state == DONE);
   assign bus.busy     = (state != IDLE);
   assign bus.sync_err = sync_err;
endmodule

// File: tb/tb_rfin_packet_rx.sv
// Directed bench for rfin_packet_rx: clean, broken-preamble, jitter, rx_en drop,
// mid-packet reset, period clamp and glitch scenarios.
module tb_rfin_packet_rx;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rfin_packet_rx_if #(.PACKET_SIZE(24), .CNT_W(16)) bus ();

   rfin_packet_rx #(.PACKET_SIZE(24), .PREAMBLE_LEN(8), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int unsigned rec_cnt = 0;
   int unsigned err_cnt = 0;
   int unsigned both_cnt = 0;
   logic [23:0] last_sent = 24'h0;

   always @(negedge clk) begin
      if (bus.pkt_rec) rec_cnt++;
      if (bus.sync_err) err_cnt++;
      if (bus.pkt_rec && bus.sync_err) both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Slot k starts at k*period (+ jitter); pattern bit 31-k high means send a pulse.
   task automatic send_slots(input logic [31:0] pat, input int n_slots, input int period,
                             input int high_len, input int jit, input int glitch_slot);
      int cur, t, off;
      cur = 0;
      for (int k = 0; k < n_slots; k++) begin
         off = (jit > 0 && k > 0) ? int'($urandom_range(2 * jit, 0)) - jit : 0;
         t = k * period + off;
         repeat (t - cur) @(negedge clk);
         cur = t;
         if (pat[31-k]) begin
            bus.rfin = 1'b1;
            repeat (high_len) @(negedge clk);
            bus.rfin = 1'b0;
            cur += high_len;
         end else if (k == glitch_slot) begin
            repeat (30) @(negedge clk);
            bus.rfin = 1'b1;
            @(negedge clk);
            bus.rfin = 1'b0;
            cur += 31;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rfin = 1'b0;
      bus.rx_en = 1'b1;
      bus.count_val = 16'd100;
      repeat (3) @(negedge clk);
      checks++; if (bus.pkt_data !== 24'h0) begin errors++; $display("FAIL reset_pkt_data: got %h expected %h", bus.pkt_data, 24'h0); end
      checks++; if (bus.pkt_rec !== 1'b0) begin errors++; $display("FAIL reset_pkt_rec: got %b expected 0", bus.pkt_rec); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", bus.sync_err); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_clean();
      int unsigned r0, e0;
      r0 = rec_cnt; e0 = err_cnt;
      send_slots({8'hFF, 24'hA5C3F0}, 32, 100, 10, 0, -1);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clean_busy_mid: got %b expected 1", bus.busy); end
      repeat (120) @(negedge clk);
      checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL clean_rec_count: got %0d expected 1", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== 24'hA5C3F0) begin errors++; $display("FAIL clean_data: got %h expected %h", bus.pkt_data, 24'hA5C3F0); end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL clean_sync_err: got %0d expected 0", err_cnt - e0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clean_busy_after: got %b expected 0", bus.busy); end
      last_sent = 24'hA5C3F0;
   endtask

   task automatic test_broken_preamble();
      int unsigned r0, e0;
      r0 = rec_cnt; e0 = err_cnt;
      send_slots(32'hF800_0000, 6, 100, 10, 0, -1);
      repeat (150) @(negedge clk);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL broken_sync_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (rec_cnt != r0) begin errors++; $display("FAIL broken_no_rec: got %0d expected 0", rec_cnt - r0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL broken_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.pkt_data !== 24'hA5C3F0) begin errors++; $display("FAIL broken_data_hold: got %h expected %h", bus.pkt_data, 24'hA5C3F0); end
      send_slots({8'hFF, 24'h000001}, 32, 100, 10, 0, -1);
      repeat (120) @(negedge clk);
      checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL broken_next_rec: got %0d expected 1", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== 24'h000001) begin errors++; $display("FAIL broken_next_data: got %h expected %h", bus.pkt_data, 24'h000001); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL broken_next_sync_err: got %0d expected 1", err_cnt - e0); end
      last_sent = 24'h000001;
   endtask

   task automatic test_jitter();
      int unsigned r0;
      logic [23:0] w;
      for (int n = 0; n < 12; n++) begin
         r0 = rec_cnt;
         w = 24'($urandom);
         send_slots({8'hFF, w}, 32, 100, 10, 5, -1);
         repeat (120) @(negedge clk);
         checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL jitter_rec[%0d]: got %0d expected 1", n, rec_cnt - r0); end
         checks++; if (bus.pkt_data !== w) begin errors++; $display("FAIL jitter_data[%0d]: got %h expected %h", n, bus.pkt_data, w); end
         last_sent = w;
      end
   endtask

   task automatic test_rx_en_drop();
      int unsigned r0, e0;
      r0 = rec_cnt; e0 = err_cnt;
      send_slots({8'hFF, 24'hFFFFFF}, 20, 100, 10, 0, -1);
      repeat (60) @(negedge clk);
      bus.rx_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rxen_busy: got %b expected 0", bus.busy); end
      repeat (200) @(negedge clk);
      checks++; if (rec_cnt != r0) begin errors++; $display("FAIL rxen_no_rec: got %0d expected 0", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== last_sent) begin errors++; $display("FAIL rxen_data_hold: got %h expected %h", bus.pkt_data, last_sent); end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL rxen_sync_err: got %0d expected 0", err_cnt - e0); end
      bus.rx_en = 1'b1;
      repeat (5) @(negedge clk);
      send_slots({8'hFF, 24'hFFFFFF}, 32, 100, 10, 0, -1);
      repeat (120) @(negedge clk);
      checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL rxen_next_rec: got %0d expected 1", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== 24'hFFFFFF) begin errors++; $display("FAIL rxen_next_data: got %h expected %h", bus.pkt_data, 24'hFFFFFF); end
      last_sent = 24'hFFFFFF;
   endtask

   task automatic test_rst_mid();
      int unsigned r0;
      r0 = rec_cnt;
      send_slots({8'hFF, 24'h0F0F0F}, 28, 100, 10, 0, -1);
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.pkt_data !== 24'h0) begin errors++; $display("FAIL rst_pkt_data: got %h expected %h", bus.pkt_data, 24'h0); end
      checks++; if (bus.pkt_rec !== 1'b0) begin errors++; $display("FAIL rst_pkt_rec: got %b expected 0", bus.pkt_rec); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err: got %b expected 0", bus.sync_err); end
      repeat (100) @(negedge clk);
      checks++; if (rec_cnt != r0) begin errors++; $display("FAIL rst_no_rec: got %0d expected 0", rec_cnt - r0); end
      send_slots({8'hFF, 24'h123456}, 32, 100, 10, 0, -1);
      repeat (120) @(negedge clk);
      checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL rst_next_rec: got %0d expected 1", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== 24'h123456) begin errors++; $display("FAIL rst_next_data: got %h expected %h", bus.pkt_data, 24'h123456); end
      last_sent = 24'h123456;
   endtask

   task automatic test_period_clamp();
      int unsigned r0;
      r0 = rec_cnt;
      bus.count_val = 16'd2;
      send_slots({8'hFF, 24'h3C5A96}, 32, 4, 2, 0, -1);
      repeat (40) @(negedge clk);
      checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL clamp_rec: got %0d expected 1", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== 24'h3C5A96) begin errors++; $display("FAIL clamp_data: got %h expected %h", bus.pkt_data, 24'h3C5A96); end
      bus.count_val = 16'd100;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_glitch();
      int unsigned r0;
      logic [23:0] exp_w;
`ifdef RFIN_GLITCH_FILTER_EN
      exp_w = 24'h800000;
`else
      exp_w = 24'h840000;
`endif
      r0 = rec_cnt;
      send_slots({8'hFF, 24'h800000}, 32, 100, 10, 0, 13);
      repeat (150) @(negedge clk);
      checks++; if (rec_cnt - r0 != 1) begin errors++; $display("FAIL glitch_rec: got %0d expected 1", rec_cnt - r0); end
      checks++; if (bus.pkt_data !== exp_w) begin errors++; $display("FAIL glitch_data: got %h expected %h", bus.pkt_data, exp_w); end
   endtask

   task automatic test_exclusive();
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL rec_err_overlap: got %0d cycles expected 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_broken_preamble();
      test_jitter();
      test_rx_en_drop();
      test_rst_mid();
      test_period_clamp();
      test_glitch();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
